// File: rtl/note_player.sv
// Monophonic note player: requests notes from a pattern sequencer, times them in
// tempo ticks and produces a gated square-wave tone at the note's pitch.
module note_player #(
  parameter int TICKS_PER_UNIT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_tick,
  input  logic        i_osc_stb,
  output logic        o_note_stb,
  input  logic        i_note_valid,
  input  logic [5:0]  i_note,
  input  logic [4:0]  i_note_len,
  input  logic [3:0]  i_instrument,
  output logic        o_gate,
  output logic [11:0] o_period,
  output logic [3:0]  o_instrument,
  output logic        o_square
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    PLAY = 2'd3
  } state_t;

  localparam logic [9:0] TPU_C = 10'(TICKS_PER_UNIT);

  state_t      state_r;
  logic        playing_r;
  logic [9:0]  cnt_r;
  logic        gate_r;
  logic [11:0] period_r;
  logic [3:0]  instr_r;
  logic [11:0] phase_r;
  logic        square_r;

  logic        latch_s;
  logic        note_end_s;
  logic [11:0] new_period_s;
  logic [9:0]  len_units_s;

  // Octave 0 half-periods, shifted right once per octave above it
  function automatic logic [11:0] pitch_period(input logic [5:0] note);
    logic [5:0]  n;
    logic [3:0]  semi;
    logic [2:0]  oct;
    logic [11:0] base;
    n    = note - 6'd1;
    semi = 4'(n % 6'd12);
    oct  = 3'(n / 6'd12);
    case (semi)
      4'd0:    base = 12'd3420;
      4'd1:    base = 12'd3228;
      4'd2:    base = 12'd3047;
      4'd3:    base = 12'd2876;
      4'd4:    base = 12'd2714;
      4'd5:    base = 12'd2562;
      4'd6:    base = 12'd2418;
      4'd7:    base = 12'd2282;
      4'd8:    base = 12'd2154;
      4'd9:    base = 12'd2033;
      4'd10:   base = 12'd1919;
      4'd11:   base = 12'd1811;
      default: base = 12'd0;
    endcase
    if (note == 6'd0) begin
      return 12'd0;
    end else begin
      return base >> oct;
    end
  endfunction

  assign latch_s      = (state_r == WAIT) && i_note_valid;
  assign note_end_s   = (state_r == PLAY) && i_tick && (cnt_r == 10'd1);
  assign new_period_s = pitch_period(i_note);
  assign len_units_s  = {5'd0, i_note_len} + 10'd1;

  // The legato request must coincide with the final tick, so it cannot wait a cycle
  assign o_note_stb   = (state_r == REQ) || (note_end_s && i_enable);

  assign o_gate       = gate_r;
  assign o_period     = period_r;
  assign o_instrument = instr_r;
  assign o_square     = square_r;

  // Playback sequencing, note timing and latched note attributes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      playing_r <= 1'b0;
      cnt_r     <= 10'd0;
      gate_r    <= 1'b0;
      period_r  <= 12'd0;
      instr_r   <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          playing_r <= 1'b0;
          gate_r    <= 1'b0;
          if (i_enable) begin
            state_r <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (i_note_valid) begin
            period_r  <= new_period_s;
            instr_r   <= i_instrument;
            playing_r <= 1'b1;
            gate_r    <= (i_note != 6'd0);
            cnt_r     <= 10'(len_units_s * TPU_C);
            state_r   <= PLAY;
          end else begin
            state_r <= WAIT;
          end
        end
        PLAY: begin
          if (i_tick) begin
            cnt_r <= cnt_r - 10'd1;
            if (cnt_r == 10'd1) begin
              if (i_enable) begin
                state_r <= WAIT;
              end else begin
                state_r   <= IDLE;
                playing_r <= 1'b0;
                gate_r    <= 1'b0;
              end
            end else begin
              state_r <= PLAY;
            end
          end else begin
            state_r <= PLAY;
          end
        end
        default: begin
          state_r   <= IDLE;
          playing_r <= 1'b0;
          gate_r    <= 1'b0;
        end
      endcase
    end
  end

  // Tone oscillator: restarts cleanly on every new note, silent while ungated
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_r  <= 12'd0;
      square_r <= 1'b0;
    end else if (latch_s) begin
      phase_r  <= new_period_s;
      square_r <= 1'b0;
    end else if (!(gate_r && playing_r)) begin
      phase_r  <= 12'd0;
      square_r <= 1'b0;
    end else if (i_osc_stb) begin
      if (phase_r == 12'd0) begin
        phase_r  <= period_r;
        square_r <= ~square_r;
      end else begin
        phase_r <= phase_r - 12'd1;
      end
    end else begin
      phase_r <= phase_r;
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Scenario bench for note_player: expected note attributes are queued when a
// note is offered and compared when the DUT presents the latched note.
module tb_note_player;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_enable;
  logic        i_tick;
  logic        i_osc_stb;
  logic        o_note_stb;
  logic        i_note_valid;
  logic [5:0]  i_note;
  logic [4:0]  i_note_len;
  logic [3:0]  i_instrument;
  logic        o_gate;
  logic [11:0] o_period;
  logic [3:0]  o_instrument;
  logic        o_square;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_period_q[$];
  logic [3:0]  exp_instr_q[$];
  logic        exp_gate_q[$];

  note_player #(.TICKS_PER_UNIT(1)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_enable     (i_enable),
    .i_tick       (i_tick),
    .i_osc_stb    (i_osc_stb),
    .o_note_stb   (o_note_stb),
    .i_note_valid (i_note_valid),
    .i_note       (i_note),
    .i_note_len   (i_note_len),
    .i_instrument (i_instrument),
    .o_gate       (o_gate),
    .o_period     (o_period),
    .o_instrument (o_instrument),
    .o_square     (o_square)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [11:0] model_period(input int note);
    int tbl[12];
    int n, oct, p;
    tbl = '{3420, 3228, 3047, 2876, 2714, 2562, 2418, 2282, 2154, 2033, 1919, 1811};
    if (note == 0) return 12'd0;
    n = note - 1;
    oct = 0;
    while (n >= 12) begin
      n = n - 12;
      oct++;
    end
    p = tbl[n];
    for (int k = 0; k < oct; k++) p = p / 2;
    return 12'(p);
  endfunction

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_note(input logic [5:0] n, input logic [4:0] len, input logic [3:0] ins);
    exp_period_q.push_back(model_period(int'(n)));
    exp_instr_q.push_back(ins);
    exp_gate_q.push_back(n != 6'd0);
    i_note = n;
    i_note_len = len;
    i_instrument = ins;
    i_note_valid = 1'b1;
    cyc();
    i_note_valid = 1'b0;
    #1;
  endtask

  task automatic do_tick(output logic stb_seen);
    i_tick = 1'b1;
    #1;
    stb_seen = o_note_stb;
    cyc();
    i_tick = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_enable = 1'b0;
    i_tick = 1'b0;
    i_osc_stb = 1'b0;
    i_note_valid = 1'b0;
    i_note = 6'd0;
    i_note_len = 5'd0;
    i_instrument = 4'd0;
    repeat (3) cyc();
    checks++; if (o_note_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %0b exp 0", o_note_stb); end
    checks++; if (o_gate !== 1'b0) begin errors++; $display("FAIL reset_gate got %0b exp 0", o_gate); end
    checks++; if (o_period !== 12'd0) begin errors++; $display("FAIL reset_period got %0d exp 0", o_period); end
    checks++; if (o_instrument !== 4'd0) begin errors++; $display("FAIL reset_instr got %0d exp 0", o_instrument); end
    checks++; if (o_square !== 1'b0) begin errors++; $display("FAIL reset_square got %0b exp 0", o_square); end
    i_rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_request();
    int extra;
    i_enable = 1'b1;
    #1;
    checks++; if (o_note_stb !== 1'b0) begin errors++; $display("FAIL req_early got %0b exp 0", o_note_stb); end
    cyc();
    checks++; if (o_note_stb !== 1'b1) begin errors++; $display("FAIL req_pulse got %0b exp 1", o_note_stb); end
    cyc();
    checks++; if (o_note_stb !== 1'b0) begin errors++; $display("FAIL req_width got %0b exp 0", o_note_stb); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_note_stb === 1'b1) extra++;
      cyc();
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL req_wait_quiet got %0d pulses exp 0", extra); end
  endtask

  task automatic test_play_legato();
    logic [11:0] ep;
    logic [3:0]  ei;
    logic        eg;
    logic        s;
    send_note(6'd1, 5'd3, 4'd7);
    ep = exp_period_q.pop_front(); ei = exp_instr_q.pop_front(); eg = exp_gate_q.pop_front();
    checks++; if (o_period !== ep) begin errors++; $display("FAIL n1_period got %0d exp %0d", o_period, ep); end
    checks++; if (o_instrument !== ei) begin errors++; $display("FAIL n1_instr got %0d exp %0d", o_instrument, ei); end
    checks++; if (o_gate !== eg) begin errors++; $display("FAIL n1_gate got %0b exp %0b", o_gate, eg); end
    do_tick(s);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL n1_tick1 got %0b exp 0", s); end
    do_tick(s);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL n1_tick2 got %0b exp 0", s); end
    // a stray response while playing must be ignored
    i_note = 6'd40; i_instrument = 4'd3; i_note_valid = 1'b1;
    cyc();
    i_note_valid = 1'b0;
    checks++; if (o_period !== ep) begin errors++; $display("FAIL stray_valid_period got %0d exp %0d", o_period, ep); end
    do_tick(s);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL n1_tick3 got %0b exp 0", s); end
    do_tick(s);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL n1_tick4_stb got %0b exp 1", s); end
    checks++; if (o_gate !== 1'b1) begin errors++; $display("FAIL legato_gate got %0b exp 1", o_gate); end
  endtask

  task automatic test_periods();
    logic [11:0] ep;
    logic [3:0]  ei;
    logic        eg;
    logic        s;
    send_note(6'd13, 5'd0, 4'd2);
    ep = exp_period_q.pop_front(); ei = exp_instr_q.pop_front(); eg = exp_gate_q.pop_front();
    checks++; if (o_period !== ep) begin errors++; $display("FAIL n13_period got %0d exp %0d", o_period, ep); end
    checks++; if (o_instrument !== ei) begin errors++; $display("FAIL n13_instr got %0d exp %0d", o_instrument, ei); end
    do_tick(s);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL n13_end_stb got %0b exp 1", s); end
    send_note(6'd63, 5'd1, 4'd15);
    ep = exp_period_q.pop_front(); ei = exp_instr_q.pop_front(); eg = exp_gate_q.pop_front();
    checks++; if (o_period !== ep) begin errors++; $display("FAIL n63_period got %0d exp %0d", o_period, ep); end
    checks++; if (o_instrument !== ei) begin errors++; $display("FAIL n63_instr got %0d exp %0d", o_instrument, ei); end
    checks++; if (o_gate !== eg) begin errors++; $display("FAIL n63_gate got %0b exp %0b", o_gate, eg); end
  endtask

  task automatic test_oscillator();
    int t1, t2;
    logic prev, s;
    t1 = 0; t2 = 0;
    prev = o_square;
    i_osc_stb = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      cyc();
      if (o_square !== prev) begin
        if (t1 == 0) t1 = i;
        else if (t2 == 0) t2 = i;
      end
      prev = o_square;
    end
    checks++; if (t1 != 96) begin errors++; $display("FAIL osc_first_toggle got %0d exp 96", t1); end
    checks++; if (t2 != 192) begin errors++; $display("FAIL osc_second_toggle got %0d exp 192", t2); end
    // ticks coinciding with oscillator strobes
    do_tick(s);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL n63_tick1 got %0b exp 0", s); end
    do_tick(s);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL n63_end_stb got %0b exp 1", s); end
    i_osc_stb = 1'b0;
  endtask

  task automatic test_rest();
    logic [11:0] ep;
    logic [3:0]  ei;
    logic        eg;
    logic        s;
    send_note(6'd0, 5'd0, 4'd3);
    ep = exp_period_q.pop_front(); ei = exp_instr_q.pop_front(); eg = exp_gate_q.pop_front();
    checks++; if (o_period !== ep) begin errors++; $display("FAIL rest_period got %0d exp %0d", o_period, ep); end
    checks++; if (o_gate !== eg) begin errors++; $display("FAIL rest_gate got %0b exp %0b", o_gate, eg); end
    i_osc_stb = 1'b1;
    repeat (4) cyc();
    checks++; if (o_square !== 1'b0) begin errors++; $display("FAIL rest_square got %0b exp 0", o_square); end
    do_tick(s);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL rest_end_stb got %0b exp 1", s); end
    i_osc_stb = 1'b0;
  endtask

  task automatic test_disable_and_reset();
    logic [11:0] ep;
    logic [3:0]  ei;
    logic        eg;
    logic        s;
    int          extra;
    send_note(6'd5, 5'd2, 4'd9);
    ep = exp_period_q.pop_front(); ei = exp_instr_q.pop_front(); eg = exp_gate_q.pop_front();
    checks++; if (o_period !== ep) begin errors++; $display("FAIL n5_period got %0d exp %0d", o_period, ep); end
    checks++; if (o_instrument !== ei) begin errors++; $display("FAIL n5_instr got %0d exp %0d", o_instrument, ei); end
    do_tick(s);
    i_enable = 1'b0;
    do_tick(s);
    checks++; if (o_gate !== 1'b1) begin errors++; $display("FAIL n5_gate_mid got %0b exp 1", o_gate); end
    do_tick(s);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL n5_end_nostb got %0b exp 0", s); end
    checks++; if (o_gate !== 1'b0) begin errors++; $display("FAIL n5_idle_gate got %0b exp 0", o_gate); end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_note_stb === 1'b1) extra++;
      cyc();
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL idle_quiet got %0d pulses exp 0", extra); end
    i_enable = 1'b1;
    cyc();
    cyc();
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_period !== 12'd0) begin errors++; $display("FAIL async_rst_period got %0d exp 0", o_period); end
    checks++; if (o_instrument !== 4'd0) begin errors++; $display("FAIL async_rst_instr got %0d exp 0", o_instrument); end
    checks++; if (o_note_stb !== 1'b0) begin errors++; $display("FAIL async_rst_stb got %0b exp 0", o_note_stb); end
    checks++; if (o_gate !== 1'b0 || o_square !== 1'b0) begin errors++; $display("FAIL async_rst_gate_sq got %0b%0b exp 00", o_gate, o_square); end
    repeat (2) cyc();
    i_rst_n = 1'b1;
    #1;
    checks++; if (o_note_stb !== 1'b0) begin errors++; $display("FAIL post_rst_early got %0b exp 0", o_note_stb); end
    cyc();
    checks++; if (o_note_stb !== 1'b1) begin errors++; $display("FAIL post_rst_req got %0b exp 1", o_note_stb); end
  endtask

  initial begin
    test_reset();
    test_request();
    test_play_legato();
    test_periods();
    test_oscillator();
    test_rest();
    test_disable_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 Parameter: TICKS_PER_UNIT, default 1, number of i_tick pulses per note-length unit (range 1..15).
REQ-002 Port: i_clk, input, 1, single clock; all state changes on rising edge.
REQ-003 Port: i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port: i_enable, input, 1, playback enable; level, sampled each cycle.
REQ-005 Port: i_tick, input, 1, tempo strobe, one-cycle pulse.
REQ-006 Port: i_osc_stb, input, 1, oscillator prescale strobe, one-cycle pulse.
REQ-007 Port: o_note_stb, output, 1, one-cycle request to pattern_sequencer for the next note.
REQ-008 Port: i_note_valid, input, 1, sequencer response strobe qualifying i_note/i_note_len/i_instrument.
REQ-009 Port: i_note, input, 6, note code; 0 = rest, 1..63 = pitch.
REQ-010 Port: i_note_len, input, 5, length code; duration = (i_note_len+1)*TICKS_PER_UNIT ticks.
REQ-011 Port: i_instrument, input, 4, instrument id, passed through.
REQ-012 Port: o_gate, output, 1, high while a non-rest note sounds.
REQ-013 Port: o_period, output, 12, half-period of current pitch in i_osc_stb units.
REQ-014 Port: o_instrument, output, 4, latched instrument of current note.
REQ-015 Port: o_square, output, 1, square-wave tone output.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, PLAY; a playing flag marks that a note has been latched since leaving IDLE.
REQ-017 IDLE: when i_enable=1, go to REQ next cycle; otherwise stay, playing=0.
REQ-018 REQ: assert o_note_stb for exactly one cycle, go to WAIT.
REQ-019 WAIT: on i_note_valid=1, latch note/len/instrument, load remaining-tick counter with (i_note_len+1)*TICKS_PER_UNIT (10-bit), set playing=1, go to PLAY; any i_note_valid outside WAIT is ignored.
REQ-020 WAIT has no timeout; the block waits indefinitely for i_note_valid.
REQ-021 PLAY: each i_tick decrements the counter; on the i_tick where counter==1: if i_enable=1 assert o_note_stb that same cycle and go to WAIT (legato, previous note keeps sounding); if i_enable=0 go to IDLE, playing=0.
REQ-022 i_enable deassertion mid-note has no effect until note end.
REQ-023 Period: n=note-1, semitone=n mod 12, octave=n div 12; o_period = TABLE[semitone] >> octave, TABLE = 3420,3228,3047,2876,2714,2562,2418,2282,2154,2033,1919,1811.
REQ-024 o_period and o_instrument update in the cycle after the latching i_note_valid; o_period=0 for a rest.
REQ-025 o_gate = playing AND latched note != 0, registered.
REQ-026 Oscillator: 12-bit phase counter; when o_gate=1 and i_osc_stb=1: if phase==0 reload with o_period and toggle o_square, else decrement.
REQ-027 On each note latch: phase loaded with the new period, o_square cleared.
REQ-028 When o_gate=0: phase=0, o_square=0.
REQ-029 Simultaneous i_tick and i_osc_stb are both processed in the same cycle.

Reset
REQ-030 i_rst_n=0 asynchronously forces state IDLE, playing=0, counter=0, phase=0, o_note_stb=0, o_gate=0, o_period=0, o_instrument=0, o_square=0.
REQ-031 Reset asserted mid-note or mid-WAIT aborts immediately; after release, the first request occurs no earlier than the second cycle with i_enable=1.

Verification
REQ-032 Enable from reset -> single o_note_stb pulse exactly 1 cycle after IDLE sees i_enable=1; no further pulse until the note ends.
REQ-033 Respond note=1, len=3, TICKS_PER_UNIT=1 -> o_period=3420, o_gate=1; next o_note_stb on the 4th i_tick, same cycle.
REQ-034 Note=13 -> o_period=1710; note=63 (semitone 2, octave 5) -> o_period=95.
REQ-035 Note=0 (rest), len=0 -> o_gate=0, o_square=0 for one tick, then request.
REQ-036 Period=95, i_osc_stb every cycle -> o_square toggles every 96 strobes.
REQ-037 Drop i_enable mid-note, then reset during WAIT -> note completes, returns to IDLE with no o_note_stb; reset forces all outputs 0.
